vga_out_stage: RTL and testbench
================================

Name: vga_out_stage

Overview:
- Sits directly downstream of the horizontal/vertical timing counter chain and the pixel-colour generator.
- Re-aligns sync and blank to the colour generator's fixed latency, forces colour to black during blanking, and holds vsync idle until the first complete frame boundary.
- Counts frames and drives the 8-bit TinyVGA PMOD output byte from a registered output stage.

Parameters:
- PIX_LATENCY, 2: cycles from hcount/vcount valid to the matching rgb_in valid; legal range 1..8.
- HSYNC_IDLE, 1: inactive hsync level (1 = negative-polarity mode).
- VSYNC_IDLE, 1: inactive vsync level.
- FRAME_W, 8: frame_count width.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- hsync_in  in  1  horizontal sync; registered one cycle after its counter value; polarity already applied
- vsync_in  in  1  vertical sync; same timing as hsync_in
- hblank_in  in  1  combinational horizontal blank, aligned to hcount_in
- vblank_in  in  1  combinational vertical blank, aligned to hcount_in
- vnext_in  in  1  one-cycle frame-end pulse: last pixel of the last line
- hcount_in  in  10  signed horizontal counter, aligned to hblank_in
- rgb_in  in  6  {r[1:0],g[1:0],b[1:0]}, valid PIX_LATENCY cycles after its hcount_in
- test_mode  in  1  colour-bar override (only used with TEST_PATTERN_EN)
- uo_out  out  8  {hsync,b0,g0,r0,vsync,b1,g1,r1}
- frame_start  out  1  one-cycle pulse on the first output pixel of each frame
- frame_count  out  FRAME_W  completed frames since RUN was entered; wraps

Behaviour:
- Reset values:
  - uo_out = {HSYNC_IDLE,3'b0,VSYNC_IDLE,3'b0}.
  - frame_start = 0, frame_count = 0.
  - FSM = WAIT.
  - All delay-line stages cleared to the idle/blank value.
- Alignment (all paths total to the same latency):
  - Blank: blank = hblank_in | vblank_in, delayed PIX_LATENCY cycles.
  - Sync: delayed PIX_LATENCY-1 cycles. PIX_LATENCY = 1 means zero extra delay.
  - Output register: adds 1 cycle to every path.
  - End-to-end: uo_out at cycle t+PIX_LATENCY+1 reflects the counter state at cycle t.
- Colour: when delayed blank = 1, colour bits are 0. Otherwise they carry rgb_in.
- FSM WAIT:
  - hsync passes through, aligned.
  - vsync forced to VSYNC_IDLE; colour forced to 0.
  - frame_count holds.
  - On vnext_in = 1, go to RUN. This transition does not increment frame_count.
- FSM RUN:
  - All fields pass through aligned.
  - Each vnext_in increments frame_count mod 2^FRAME_W.
  - The RUN-entry vnext_in and each later vnext_in is delayed PIX_LATENCY+1 cycles and emitted as frame_start. frame_start therefore coincides with the first output pixel of the new frame.
- Output switching: the WAIT→RUN change is applied at the output register the same cycle frame_start would fire. No partial frame ever shows the vsync pulse.
- Simultaneous events: vnext_in during reset is ignored. reset_n low mid-frame returns to WAIT on the next edge; all outputs take their reset values on that edge.
- frame_count wraps from 2^FRAME_W-1 to 0 with no flag.
- No back-pressure; every cycle is a pixel.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined:
  - When test_mode = 1, rgb_in is replaced by 8 colour bars.
  - Bar index = hcount_in[8:6]; colour = {idx[2],idx[2],idx[1],idx[1],idx[0],idx[0]}.
  - The bar colour is computed at the input and carried through its own PIX_LATENCY delay so it aligns like rgb_in.
  - Blanking still applies.
  - test_mode is sampled per pixel with no glitch suppression.
- Not defined: test_mode is ignored and the delay line is not instantiated.

Decomposition:
- Shared package vga_pkg:
  - typedef rgb222_t (packed r,g,b 2-bit fields).
  - enum out_state_t {WAIT, RUN}.
  - constant PMOD bit positions.
- One sub-module: vga_delay_line.
  - Parameterised width and depth (depth 0 = wire).
  - Synchronous active-low reset to a parameterised value.
  - Used for blank, sync, frame pulse and test colour.

Test Plan:
1. Reset, then hold hsync_in = 0, vsync_in = 0, rgb_in = 6'h3F, blank = 0 → uo_out[3] (vsync) = 1 and colour = 0 while in WAIT; hsync bit follows input after 2 cycles (PIX_LATENCY = 2).
2. Pulse vnext_in at t = 100 → frame_start = 1 at t = 103 only; frame_count stays 0; vsync and colour pass through from t = 103.
3. In RUN, single-cycle hblank_in = 1 at t, rgb_in = 6'h15 constant → colour bits 0 only at t+3; hsync_in edge at t+1 appears on uo_out[7] at t+3.
4. 256 vnext_in pulses in RUN with FRAME_W = 8 → frame_count goes 255 → 0.
5. reset_n low for one cycle mid-frame in RUN → next cycle: uo_out = 8'h88, FSM back in WAIT, frame_count = 0.
6. With TEST_PATTERN_EN, test_mode = 1, hcount_in = 10'd320 (idx = 5), no blank → colour output = 6'b110011 three cycles later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and PMOD bit map for the VGA output stage.
package vga_pkg;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  typedef enum logic {
    WAIT,
    RUN
  } out_state_t;

  // TinyVGA PMOD byte: {hsync,b0,g0,r0,vsync,b1,g1,r1}
  localparam int PMOD_HSYNC = 7;
  localparam int PMOD_B0    = 6;
  localparam int PMOD_G0    = 5;
  localparam int PMOD_R0    = 4;
  localparam int PMOD_VSYNC = 3;
  localparam int PMOD_B1    = 2;
  localparam int PMOD_G1    = 1;
  localparam int PMOD_R1    = 0;

  function automatic logic [7:0] pack_pmod(logic hs, logic vs, rgb222_t c);
    logic [7:0] p;
    p             = '0;
    p[PMOD_HSYNC] = hs;
    p[PMOD_B0]    = c.b[0];
    p[PMOD_G0]    = c.g[0];
    p[PMOD_R0]    = c.r[0];
    p[PMOD_VSYNC] = vs;
    p[PMOD_B1]    = c.b[1];
    p[PMOD_G1]    = c.g[1];
    p[PMOD_R1]    = c.r[1];
    return p;
  endfunction

  // Eight bars: each index bit drives both bits of one colour channel.
  function automatic rgb222_t bar_colour(logic [2:0] idx);
    rgb222_t c;
    c.r = {2{idx[2]}};
    c.g = {2{idx[1]}};
    c.b = {2{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_out_stage_if.sv
// Timing-chain and colour-generator signals feeding the VGA output stage.
interface vga_out_stage_if;
  logic              hsync_in;
  logic              vsync_in;
  logic              hblank_in;
  logic              vblank_in;
  logic              vnext_in;
  logic signed [9:0] hcount_in;
  logic [5:0]        rgb_in;

  modport master (
    output hsync_in, vsync_in, hblank_in, vblank_in, vnext_in, hcount_in, rgb_in
  );

  modport slave (
    input hsync_in, vsync_in, hblank_in, vblank_in, vnext_in, hcount_in, rgb_in
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line; depth 0 is a plain wire.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset_n;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_out_stage.sv
// VGA output stage: aligns sync/blank to colour latency, holds vsync idle until the first frame boundary.
// Define TEST_PATTERN_EN to add the test_mode colour-bar override.
module vga_out_stage
  import vga_pkg::*;
#(
  parameter int PIX_LATENCY = 2,
  parameter bit HSYNC_IDLE  = 1'b1,
  parameter bit VSYNC_IDLE  = 1'b1,
  parameter int FRAME_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_out_stage_if.slave     vin,
  input  logic               test_mode,
  output logic [7:0]         uo_out,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  out_state_t state;
  logic       out_run;
  logic       blank_d;
  logic       vnext_d;
  logic       run_now;
  logic [1:0] sync_d;
  rgb222_t    pix_colour;
  rgb222_t    colour;

  vga_delay_line #(.WIDTH(1), .DEPTH(PIX_LATENCY), .RESET_VAL(1'b1)) u_blank_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vin.hblank_in | vin.vblank_in),
    .q       (blank_d)
  );

  // Sync is already one cycle late relative to the counters.
  vga_delay_line #(.WIDTH(2), .DEPTH(PIX_LATENCY - 1), .RESET_VAL({HSYNC_IDLE, VSYNC_IDLE})) u_sync_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({vin.hsync_in, vin.vsync_in}),
    .q       (sync_d)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(PIX_LATENCY), .RESET_VAL(1'b0)) u_frame_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vin.vnext_in),
    .q       (vnext_d)
  );

`ifdef TEST_PATTERN_EN
  logic [6:0] tp_d;
  logic       unused_hcount;

  assign unused_hcount = ^{vin.hcount_in[9], vin.hcount_in[5:0]};

  vga_delay_line #(.WIDTH(7), .DEPTH(PIX_LATENCY), .RESET_VAL(7'd0)) u_tp_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({test_mode, bar_colour(vin.hcount_in[8:6])}),
    .q       (tp_d)
  );

  assign pix_colour = tp_d[6] ? rgb222_t'(tp_d[5:0]) : rgb222_t'(vin.rgb_in);
`else
  logic unused_tp;

  assign unused_tp  = ^{test_mode, vin.hcount_in};
  assign pix_colour = rgb222_t'(vin.rgb_in);
`endif

  // The frame pulse itself switches the output into RUN so no partial frame leaks out.
  assign run_now = out_run | vnext_d;
  assign colour  = (run_now && !blank_d) ? pix_colour : rgb222_t'(6'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= WAIT;
      out_run     <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      uo_out      <= pack_pmod(HSYNC_IDLE, VSYNC_IDLE, rgb222_t'(6'd0));
    end else begin
      case (state)
        WAIT:    if (vin.vnext_in) state <= RUN;
        RUN:     if (vin.vnext_in) frame_count <= frame_count + FRAME_W'(1);
        default: state <= WAIT;
      endcase
      if (vnext_d) out_run <= 1'b1;
      frame_start <= vnext_d;
      uo_out      <= pack_pmod(sync_d[1], run_now ? sync_d[0] : VSYNC_IDLE, colour);
    end
  end

endmodule

// File: tb/tb_vga_out_stage.sv
// Scoreboard bench for vga_out_stage: one expected output per driven cycle, compared after the clock edge.
module tb_vga_out_stage;
  import vga_pkg::*;

  localparam int MAXC = 4096;

  typedef struct {
    logic [7:0] uo;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       test_mode = 1'b0;
  logic [7:0] uo_out;
  logic       frame_start;
  logic [7:0] frame_count;

  int         k = 0;
  int         checks = 0;
  int         failures = 0;

  bit         h_hs    [MAXC];
  bit         h_vs    [MAXC];
  bit         h_blank [MAXC];
  bit         h_vn    [MAXC];
  bit         h_tm    [MAXC];
  logic [5:0] h_bar   [MAXC];
  bit         run_m = 1'b0;
  bit         state_run_m = 1'b0;
  logic [7:0] cnt_m = '0;

  vga_out_stage_if vif ();

  vga_out_stage #(
    .PIX_LATENCY (2),
    .HSYNC_IDLE  (1'b1),
    .VSYNC_IDLE  (1'b1),
    .FRAME_W     (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vin         (vif),
    .test_mode   (test_mode),
    .uo_out      (uo_out),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Record this cycle's stimulus, push the output expected after the coming edge, then clock it.
  task automatic applyStimulus();
    exp_t       e;
    logic [5:0] pix;
    logic [5:0] c;
    logic [9:0] hc;
    hc = vif.hcount_in;
    if (!reset_n) begin
      h_hs[k] = 1'b1; h_vs[k] = 1'b1; h_blank[k] = 1'b1; h_vn[k] = 1'b0; h_tm[k] = 1'b0;
      if (k > 0) begin
        h_blank[k-1] = 1'b1; h_vn[k-1] = 1'b0; h_tm[k-1] = 1'b0;
      end
      run_m = 1'b0; state_run_m = 1'b0; cnt_m = '0;
      e.uo = 8'h88; e.fs = 1'b0; e.fc = 8'd0;
    end else begin
      h_hs[k]    = vif.hsync_in;
      h_vs[k]    = vif.vsync_in;
      h_blank[k] = vif.hblank_in | vif.vblank_in;
      h_vn[k]    = vif.vnext_in;
      h_tm[k]    = test_mode;
      h_bar[k]   = {{2{hc[8]}}, {2{hc[7]}}, {2{hc[6]}}};
      run_m = run_m | h_vn[k-2];
      if (vif.vnext_in) begin
        if (state_run_m) cnt_m = cnt_m + 8'd1;
        else state_run_m = 1'b1;
      end
      pix = vif.rgb_in;
`ifdef TEST_PATTERN_EN
      if (h_tm[k-2]) pix = h_bar[k-2];
`endif
      c = (run_m && !h_blank[k-2]) ? pix : 6'd0;
      e.uo = {h_hs[k-1], c[0], c[2], c[4], run_m ? h_vs[k-1] : 1'b1, c[1], c[3], c[5]};
      e.fs = h_vn[k-2];
      e.fc = cnt_m;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    e = sb.pop_front();
    checks += 3;
    assert (uo_out === e.uo) else begin
      failures++;
      $error("[TB] FAIL %s uo_out cycle %0d: got %h expected %h", tag, k, uo_out, e.uo);
    end
    assert (frame_start === e.fs) else begin
      failures++;
      $error("[TB] FAIL %s frame_start cycle %0d: got %b expected %b", tag, k, frame_start, e.fs);
    end
    assert (frame_count === e.fc) else begin
      failures++;
      $error("[TB] FAIL %s frame_count cycle %0d: got %0d expected %0d", tag, k, frame_count, e.fc);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      h_hs[i] = 1'b1; h_vs[i] = 1'b1; h_blank[i] = 1'b1; h_vn[i] = 1'b0; h_tm[i] = 1'b0; h_bar[i] = '0;
    end
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1; vif.hblank_in = 1'b0; vif.vblank_in = 1'b0;
    vif.vnext_in = 1'b0; vif.hcount_in = '0; vif.rgb_in = '0;

    // Reset with a vnext pulse that must be ignored
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vif.vnext_in = (i == 1);
      applyStimulus(); checkOutput("reset");
    end
    vif.vnext_in = 1'b0;

    // WAIT: hsync follows, vsync idle, colour black
    reset_n = 1'b1;
    vif.vsync_in = 1'b0; vif.rgb_in = 6'h3F;
    for (int i = 0; i < 12; i++) begin
      vif.hsync_in = (i % 3 != 0);
      applyStimulus(); checkOutput("wait_hold");
    end

    // RUN entry on the first frame boundary
    vif.vnext_in = 1'b1;
    applyStimulus(); checkOutput("vnext_entry");
    vif.vnext_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vif.hsync_in = i[0];
      vif.vsync_in = (i > 4);
      applyStimulus(); checkOutput("run_entry");
    end

    // Single-cycle blanks and an hsync edge
    vif.rgb_in = 6'h15; vif.hsync_in = 1'b1; vif.vsync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin applyStimulus(); checkOutput("blank_align"); end
    vif.hblank_in = 1'b1;
    applyStimulus(); checkOutput("blank_align");
    vif.hblank_in = 1'b0; vif.hsync_in = 1'b0;
    for (int i = 0; i < 5; i++) begin applyStimulus(); checkOutput("blank_align"); end
    vif.vblank_in = 1'b1;
    applyStimulus(); checkOutput("blank_align");
    vif.vblank_in = 1'b0;
    for (int i = 0; i < 5; i++) begin applyStimulus(); checkOutput("blank_align"); end

    // 256 frames: frame_count wraps 255 -> 0
    for (int n = 0; n < 256; n++) begin
      for (int j = 0; j < 4; j++) begin
        vif.vnext_in  = (j == 0);
        vif.hsync_in  = 1'($urandom);
        vif.vsync_in  = 1'($urandom);
        vif.hblank_in = ($urandom_range(0, 7) == 0);
        vif.rgb_in    = 6'($urandom);
        test_mode     = 1'($urandom);
        applyStimulus(); checkOutput("frame_wrap");
      end
    end
    vif.vnext_in = 1'b0; vif.hblank_in = 1'b0; test_mode = 1'b0;
    checks++;
    assert (frame_count === 8'd0) else begin
      failures++;
      $error("[TB] FAIL wrap_zero frame_count: got %0d expected 0", frame_count);
    end

    // Mid-frame reset (with an ignored vnext) returns to WAIT
    vif.vsync_in = 1'b0; vif.rgb_in = 6'h2A;
    for (int i = 0; i < 4; i++) begin applyStimulus(); checkOutput("pre_reset"); end
    reset_n = 1'b0; vif.vnext_in = 1'b1;
    applyStimulus(); checkOutput("mid_reset");
    reset_n = 1'b1; vif.vnext_in = 1'b0; vif.rgb_in = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      vif.hsync_in = i[1];
      applyStimulus(); checkOutput("post_reset");
    end

    // Test-pattern request: bars with the macro defined, ignored otherwise
    vif.vnext_in = 1'b1;
    applyStimulus(); checkOutput("tp_entry");
    vif.vnext_in = 1'b0;
    for (int i = 0; i < 4; i++) begin applyStimulus(); checkOutput("tp_entry"); end
    test_mode = 1'b1; vif.hcount_in = 10'sd320; vif.rgb_in = 6'h00;
    for (int i = 0; i < 5; i++) begin applyStimulus(); checkOutput("test_mode"); end
    test_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin applyStimulus(); checkOutput("test_mode"); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
